adcv_conv_ctrl: RTL and testbench

Conversion controller for the ramp-compare TDC ADC. Each ramp period the ADC datapath delivers one fine-code sample. This block sequences conversions and calibrations over those samples:
- discards settling periods after an input-mux switch;
- averages 2^k samples;
- subtracts a stored calibration offset;
- hands the result downstream over a valid/ready handshake.

It sits between the ADC top (TDC pair plus difference logic) and the readout/host logic.

---
 rtl/adcv_pkg.sv | 32 +++
 rtl/adcv_avg_acc.sv | 59 +++++
 rtl/adcv_conv_ctrl.sv | 165 ++++++++++++++++
 tb/tb_adcv_conv_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adcv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adcv_pkg
// Purpose  : State/mode encodings and width helpers for the conversion controller.
// Revision : 1.0 - initial release
// ============================================================================
package adcv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_DONE   = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  typedef enum logic {
    MODE_CONV = 1'b0,
    MODE_CAL  = 1'b1
  } mode_t;

  // Room for 128 samples of FINE_BITS+1 bits each.
  function automatic int acc_w(input int fine_bits);
    return fine_bits + 8;
  endfunction

  function automatic int sat_max(input int fine_bits);
    return (1 << (fine_bits + 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adcv_avg_acc.sv
`default_nettype none
// ============================================================================
// Module   : adcv_avg_acc
// Purpose  : Sample accumulator, power-of-two average and saturating offset removal.
// Revision : 1.0 - initial release
// ============================================================================
module adcv_avg_acc
  import adcv_pkg::*;
#(
  parameter int FINE_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_add,
  input  logic [FINE_BITS:0]   i_sample,
  input  logic [2:0]           i_log2,
  input  logic [FINE_BITS:0]   i_offset,
  output logic                 o_last,
  output logic [FINE_BITS:0]   o_avg,
  output logic [FINE_BITS:0]   o_result
);

  localparam int SAMP_W = FINE_BITS + 1;
  localparam int ACC_W  = acc_w(FINE_BITS);
  localparam logic [SAMP_W-1:0] C_SAT_MAX = SAMP_W'(sat_max(FINE_BITS));

  logic [ACC_W-1:0]   r_acc;
  logic [7:0]         r_count;
  logic signed [SAMP_W:0] w_diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_add) begin
      r_acc   <= r_acc + ACC_W'(i_sample);
      r_count <= r_count + 8'd1;
    end
  end

  // Asserted while the sample being added now completes the 2^k set.
  assign o_last = ((r_count + 8'd1) == (8'd1 << i_log2));
  assign o_avg  = SAMP_W'(r_acc >> i_log2);
  assign w_diff = $signed({1'b0, o_avg}) - $signed({1'b0, i_offset});

  always_comb begin
    o_result = w_diff[SAMP_W-1:0];
    if (w_diff < 0)
      o_result = '0;
    else if (w_diff > $signed({1'b0, C_SAT_MAX}))
      o_result = C_SAT_MAX;
  end

endmodule
`default_nettype wire

// File: rtl/adcv_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adcv_conv_ctrl
// Purpose  : Sequences settle/average/offset-correct conversions and calibrations.
// Revision : 1.0 - initial release
// ============================================================================
module adcv_conv_ctrl
  import adcv_pkg::*;
#(
  parameter int FINE_BITS    = 6,
  parameter int SETTLE_TICKS = 2,
  parameter int MAX_MISS     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cal,
  input  logic [2:0]           avg_log2,
  input  logic                 tick,
  input  logic [FINE_BITS:0]   sample_in,
  input  logic                 hit_seen,
  output logic                 cal_sel,
  output logic                 busy,
  output logic [FINE_BITS:0]   result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 err_timeout
);

  localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE_TICKS - 1);
  localparam logic [3:0] C_MISS_LAST   = 4'(MAX_MISS - 1);

  state_t             r_state;
  mode_t              r_mode;
  logic [2:0]         r_log2;
  logic [3:0]         r_settle;
  logic [3:0]         r_miss;
  logic [FINE_BITS:0] r_offset;
  logic [FINE_BITS:0] r_result;
  logic               r_valid;
  logic               r_busy;
  logic               r_cal_sel;
  logic               r_err;

  logic               w_accept;
  logic               w_miss_tick;
  logic               w_abort;
  logic               w_acc_add;
  logic               w_acc_clr;
  logic               w_last;
  logic [FINE_BITS:0] w_avg;
  logic [FINE_BITS:0] w_corr;

  assign w_accept    = (r_state == ST_IDLE) && (start || cal);
  assign w_miss_tick = tick && !hit_seen;
  assign w_abort     = ((r_state == ST_SETTLE) || (r_state == ST_ACCUM)) &&
                       w_miss_tick && (r_miss == C_MISS_LAST);
  assign w_acc_add   = (r_state == ST_ACCUM) && tick && hit_seen;
  assign w_acc_clr   = w_accept || w_abort;

  adcv_avg_acc #(
    .FINE_BITS (FINE_BITS)
  ) u_avg_acc (
    .clk      (clock),
    .rst      (reset),
    .i_clr    (w_acc_clr),
    .i_add    (w_acc_add),
    .i_sample (sample_in),
    .i_log2   (r_log2),
    .i_offset (r_offset),
    .o_last   (w_last),
    .o_avg    (w_avg),
    .o_result (w_corr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_CONV;
      r_log2    <= '0;
      r_settle  <= '0;
      r_miss    <= '0;
      r_offset  <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_cal_sel <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_abort) begin
        r_state   <= ST_IDLE;
        r_miss    <= '0;
        r_busy    <= 1'b0;
        r_cal_sel <= 1'b0;
        r_err     <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_mode    <= cal ? MODE_CAL : MODE_CONV;
              r_log2    <= avg_log2;
              r_settle  <= '0;
              r_miss    <= '0;
              r_busy    <= 1'b1;
              r_cal_sel <= cal;
              r_state   <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (w_miss_tick)
              r_miss <= r_miss + 4'd1;
            if (SETTLE_TICKS == 0)
              r_state <= ST_ACCUM;
            else if (tick) begin
              if (r_settle == C_SETTLE_LAST)
                r_state <= ST_ACCUM;
              else
                r_settle <= r_settle + 4'd1;
            end
          end
          ST_ACCUM: begin
            if (tick) begin
              if (hit_seen) begin
                r_miss <= '0;
                if (w_last)
                  r_state <= ST_DONE;
              end else begin
                r_miss <= r_miss + 4'd1;
              end
            end
          end
          ST_DONE: begin
            if (r_mode == MODE_CAL) begin
              r_offset  <= w_avg;
              r_busy    <= 1'b0;
              r_cal_sel <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_result <= w_corr;
              r_valid  <= 1'b1;
              r_state  <= ST_OUT;
            end
          end
          ST_OUT: begin
            if (result_ready) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cal_sel      = r_cal_sel;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign err_timeout  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_adcv_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adcv_conv_ctrl
// Purpose  : Self-checking bench for adcv_conv_ctrl against a sum/shift/offset model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adcv_conv_ctrl;

  localparam int SW = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cal = 1'b0;
  logic [2:0]    avg_log2 = 3'd0;
  logic          tick = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          hit_seen = 1'b0;
  logic          result_ready = 1'b0;
  logic          cal_sel, busy, result_valid, err_timeout;
  logic [SW-1:0] result;

  int n_vec = 0;
  int n_err = 0;
  int m_offset = 0;
  int q_samp[$];
  int q_miss[$];

  always #5 clock = ~clock;

  adcv_conv_ctrl #(
    .FINE_BITS    (6),
    .SETTLE_TICKS (2),
    .MAX_MISS     (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .cal          (cal),
    .avg_log2     (avg_log2),
    .tick         (tick),
    .sample_in    (sample_in),
    .hit_seen     (hit_seen),
    .cal_sel      (cal_sel),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .err_timeout  (err_timeout)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic hit, input int s);
    tick = 1'b1;
    hit_seen = hit;
    sample_in = SW'(s);
    cyc();
    tick = 1'b0;
    hit_seen = 1'b0;
  endtask

  // hold < 0 leaves the result pending in the output stage.
  task automatic run_op(input bit is_cal, input bit both, input int k, input int hold);
    int sum;
    int avg;
    int expv;
    sum = 0;
    cal = is_cal;
    start = both | !is_cal;
    avg_log2 = 3'(k);
    cyc();
    cal = 1'b0;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || cal_sel !== is_cal) begin
      n_err++;
      $display("FAIL accept: busy=%b cal_sel=%b, want 1/%b", busy, cal_sel, is_cal);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      pulse(1'b1, int'($urandom_range(0, 127)));
    end
    for (int i = 0; i < q_samp.size(); i++) begin
      for (int j = 0; j < q_miss[i]; j++) begin
        cyc();
        pulse(1'b0, int'($urandom_range(0, 127)));
        n_vec++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL miss_no_abort: err=%b busy=%b, want 0/1", err_timeout, busy);
        end
      end
      cyc();
      pulse(1'b1, q_samp[i]);
      sum += q_samp[i];
      if (i != q_samp.size() - 1) begin
        n_vec++;
        if (busy !== 1'b1 || cal_sel !== is_cal || result_valid !== 1'b0) begin
          n_err++;
          $display("FAIL accum: busy=%b cal_sel=%b valid=%b, want 1/%b/0",
                   busy, cal_sel, result_valid, is_cal);
        end
      end
    end
    n_vec++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL done_cycle: valid=%b busy=%b, want 0/1", result_valid, busy);
    end
    cyc();
    avg = sum >> k;
    if (is_cal) begin
      m_offset = avg;
      n_vec++;
      if (busy !== 1'b0 || cal_sel !== 1'b0 || result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL cal_end: busy=%b cal_sel=%b valid=%b, want 0/0/0",
                 busy, cal_sel, result_valid);
      end
    end else begin
      expv = (avg > m_offset) ? avg - m_offset : 0;
      n_vec++;
      if (result_valid !== 1'b1 || result !== SW'(expv)) begin
        n_err++;
        $display("FAIL result: valid=%b result=%0d, want 1/%0d", result_valid, result, expv);
      end
      if (hold >= 0) begin
        for (int h = 0; h < hold; h++) begin
          if (h == 3) start = 1'b1;
          cyc();
          start = 1'b0;
          n_vec++;
          if (result_valid !== 1'b1 || result !== SW'(expv) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL hold: valid=%b result=%0d busy=%b, want 1/%0d/1",
                     result_valid, result, busy, expv);
          end
        end
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        n_vec++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL handshake: valid=%b busy=%b, want 0/0", result_valid, busy);
        end
      end
    end
  endtask

  task automatic set_ops(input int k, input int s0, input int m0);
    q_samp.delete();
    q_miss.delete();
    for (int i = 0; i < (1 << k); i++) begin
      q_samp.push_back(s0);
      q_miss.push_back(m0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_vec++;
    if ({cal_sel, busy, result_valid, err_timeout} !== 4'b0 || result !== '0) begin
      n_err++;
      $display("FAIL reset: flags=%b result=%0d, want 0000/0",
               {cal_sel, busy, result_valid, err_timeout}, result);
    end
    reset = 1'b0;
    cyc();
    n_vec++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: busy=%b valid=%b, want 0/0", busy, result_valid);
    end
    m_offset = 0;
  endtask

  task automatic test_basic();
    q_samp = '{9, 10, 11, 12};
    q_miss = '{0, 0, 0, 0};
    run_op(1'b0, 1'b0, 2, 0);
  endtask

  task automatic test_cal();
    set_ops(0, 5, 0);
    run_op(1'b1, 1'b0, 0, 0);
    set_ops(0, 3, 0);
    run_op(1'b0, 1'b0, 0, 0);
    set_ops(0, 127, 0);
    run_op(1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_miss_clear();
    q_samp = '{20, 30};
    q_miss = '{3, 3};
    run_op(1'b0, 1'b0, 1, 1);
  endtask

  task automatic test_timeout(input bit is_cal);
    cal = is_cal;
    start = !is_cal;
    avg_log2 = 3'd2;
    cyc();
    cal = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      pulse(1'b1, 1);
    end
    cyc();
    pulse(1'b1, 50);
    for (int j = 0; j < 4; j++) begin
      cyc();
      pulse(1'b0, 0);
      n_vec++;
      if (j < 3) begin
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL timeout_early: err=%b busy=%b, want 0/1", err_timeout, busy);
        end
      end else if (err_timeout !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 ||
                   cal_sel !== 1'b0) begin
        n_err++;
        $display("FAIL timeout: err=%b busy=%b valid=%b cal_sel=%b, want 1/0/0/0",
                 err_timeout, busy, result_valid, cal_sel);
      end
    end
    cyc();
    n_vec++;
    if (err_timeout !== 1'b0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_pulse: err=%b valid=%b, want 0/0", err_timeout, result_valid);
    end
  endtask

  task automatic test_hold();
    set_ops(0, 60, 0);
    run_op(1'b0, 1'b0, 0, 10);
  endtask

  task automatic test_both();
    q_samp = '{8, 10};
    q_miss = '{0, 1};
    run_op(1'b1, 1'b1, 1, 0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    avg_log2 = 3'd2;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      pulse(1'b1, 33);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({cal_sel, busy, result_valid, err_timeout} !== 4'b0 || result !== '0) begin
      n_err++;
      $display("FAIL reset_accum: flags=%b result=%0d, want 0000/0",
               {cal_sel, busy, result_valid, err_timeout}, result);
    end
    #2 reset = 1'b0;
    m_offset = 0;
    cyc();
    set_ops(0, 77, 0);
    run_op(1'b0, 1'b0, 0, -1);
    reset = 1'b1;
    #1;
    n_vec++;
    if ({cal_sel, busy, result_valid, err_timeout} !== 4'b0 || result !== '0) begin
      n_err++;
      $display("FAIL reset_out: flags=%b result=%0d, want 0000/0",
               {cal_sel, busy, result_valid, err_timeout}, result);
    end
    #2 reset = 1'b0;
    cyc();
    q_samp = '{40, 42};
    q_miss = '{0, 0};
    run_op(1'b0, 1'b0, 1, 2);
  endtask

  task automatic test_random();
    int k;
    bit is_cal;
    for (int n = 0; n < 25; n++) begin
      k = int'($urandom_range(0, 3));
      is_cal = ($urandom_range(0, 3) == 0);
      q_samp.delete();
      q_miss.delete();
      for (int i = 0; i < (1 << k); i++) begin
        q_samp.push_back(int'($urandom_range(0, 127)));
        q_miss.push_back(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      run_op(is_cal, 1'b0, k, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cal();
    test_miss_clear();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_hold();
    test_both();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
